// File: rtl/td4_pkg.sv
// Shared TD4 definitions: program-word widths, program memory depth and the
// run-controller state encoding.
//   opcode_t / imm_t / addr_t : 4-bit opcode, immediate and memory address
//   run_state_t               : IDLE=0, LOAD=1, HALT=2, RUN=3
//   is_last_addr()            : true for the highest program-memory address
package td4_pkg;

    localparam int OPC_W     = 4;
    localparam int IMM_W     = 4;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 16;

    typedef logic [OPC_W-1:0]  opcode_t;
    typedef logic [IMM_W-1:0]  imm_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HALT = 2'd2,
        ST_RUN  = 2'd3
    } run_state_t;

    function automatic logic is_last_addr(input addr_t a);
        return a == ADDR_W'(MEM_DEPTH - 1);
    endfunction

endpackage

// File: rtl/td4_run_ctrl_if.sv
// Program-load bus of the TD4 run controller.
// Handshake: a word transfers in every cycle where load_valid && load_ready
// are both high at the rising clk edge; the host keeps load_opcode/load_imm
// stable while load_valid is high, and load_ready never depends on load_valid.
//   load_valid/load_opcode/load_imm : host -> controller, one program word
//   load_ready                      : controller accepts a word this cycle
//   mem_we/mem_addr/mem_opcode/mem_imm : controller -> program memory write
// Modports: master = host/memory side, slave = run controller.
interface td4_run_ctrl_if;
    import td4_pkg::*;

    logic    load_valid;
    opcode_t load_opcode;
    imm_t    load_imm;
    logic    load_ready;
    logic    mem_we;
    addr_t   mem_addr;
    opcode_t mem_opcode;
    imm_t    mem_imm;

    modport master (
        output load_valid, load_opcode, load_imm,
        input  load_ready, mem_we, mem_addr, mem_opcode, mem_imm
    );

    modport slave (
        input  load_valid, load_opcode, load_imm,
        output load_ready, mem_we, mem_addr, mem_opcode, mem_imm
    );

endinterface

// File: rtl/td4_step_div.sv
// Clock divider producing the CPU step pulse in RUN.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear of the count (wins over enable)
//   enable   : count this cycle
//   pulse    : high while enabled and the count sits at DIV-1
// The count wraps to 0 on the pulse cycle, so pulses are DIV cycles apart.
module td4_step_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic pulse
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign pulse = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= pulse ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: loads 16 program words into program memory, then runs
// the CPU with a clock-enable pulse every DIV clk cycles.
//   clk, rst        : clock, asynchronous active-high reset
//   start_load, run, halt, step : single-cycle commands,
//                     priority start_load > halt > run > step
//   bus (slave)     : load handshake in, program-memory write port out
//   cpu_en          : one-cycle CPU clock enable
//   cpu_rst         : holds the CPU in reset (IDLE and LOAD)
//   state           : current FSM state (IDLE=0, LOAD=1, HALT=2, RUN=3)
//   step_count      : number of cpu_en pulses since the last load (wraps)
//   load_done       : all 16 words have been written
// Optional feature: macro TD4_RUN_CTRL_STEP_EN enables single-step in HALT.
module td4_run_ctrl
    import td4_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_load,
    input  logic                 run,
    input  logic                 halt,
    input  logic                 step,
    td4_run_ctrl_if.slave        bus,
    output logic                 cpu_en,
    output logic                 cpu_rst,
    output logic [1:0]           state,
    output logic [7:0]           step_count,
    output logic                 load_done
);

    run_state_t st, st_next;
    addr_t      addr;
    logic       hs;
    logic       div_pulse;
    logic       run_pulse;
    logic       mem_we_q;
    addr_t      mem_addr_q;
    opcode_t    mem_opcode_q;
    imm_t       mem_imm_q;

    // A coincident start_load restarts the load, so the word on the bus in
    // that cycle is refused rather than written to the abandoned address.
    assign bus.load_ready = (st == ST_LOAD) && !start_load;
    assign hs             = bus.load_valid && bus.load_ready;

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_opcode = mem_opcode_q;
    assign bus.mem_imm    = mem_imm_q;

    assign cpu_rst = (st == ST_IDLE) || (st == ST_LOAD);
    assign state   = st;

    always_comb begin
        st_next = st;
        if (start_load) begin
            st_next = ST_LOAD;
        end else begin
            case (st)
                ST_IDLE: st_next = ST_IDLE;
                ST_LOAD: if (hs && is_last_addr(addr)) st_next = ST_HALT;
                ST_HALT: if (!halt && run && load_done) st_next = ST_RUN;
                ST_RUN:  if (halt) st_next = ST_HALT;
                default: st_next = ST_IDLE;
            endcase
        end
    end

    // The divider only counts while staying in RUN; leaving RUN clears it so
    // the next RUN entry starts a full DIV period.
    td4_step_div #(.DIV(DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .clear  (st_next != ST_RUN),
        .enable (st == ST_RUN),
        .pulse  (div_pulse)
    );

    // A pulse due in the cycle the FSM leaves RUN is dropped.
    assign run_pulse = div_pulse && (st_next == ST_RUN);

`ifdef TD4_RUN_CTRL_STEP_EN
    logic step_pend;
    logic step_take;

    // Step has the lowest priority: any other command in the cycle wins.
    assign step_take = (st == ST_HALT) && load_done && step
                       && !start_load && !halt && !run;
    assign cpu_en    = run_pulse || (step_pend && (st == ST_HALT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_pend <= 1'b0;
        end else begin
            step_pend <= step_take;
        end
    end
`else
    logic unused_step;
    assign unused_step = step;
    assign cpu_en      = run_pulse;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= ST_IDLE;
            addr         <= '0;
            load_done    <= 1'b0;
            step_count   <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_opcode_q <= '0;
            mem_imm_q    <= '0;
        end else begin
            st       <= st_next;
            mem_we_q <= hs;
            if (hs) begin
                mem_addr_q   <= addr;
                mem_opcode_q <= bus.load_opcode;
                mem_imm_q    <= bus.load_imm;
                addr         <= addr + ADDR_W'(1);
                if (is_last_addr(addr)) begin
                    load_done <= 1'b1;
                end
            end
            if (start_load) begin
                addr       <= '0;
                load_done  <= 1'b0;
                step_count <= 8'd0;
            end else if (cpu_en) begin
                step_count <= step_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_td4_run_ctrl.sv
module tb_td4_run_ctrl;

`ifdef TD4_RUN_CTRL_STEP_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_load, run, halt, step;
    logic       cpu_en, cpu_rst, load_done;
    logic [1:0] state;
    logic [7:0] step_count;

    td4_run_ctrl_if bus ();

    td4_run_ctrl #(.DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .run        (run),
        .halt       (halt),
        .step       (step),
        .bus        (bus),
        .cpu_en     (cpu_en),
        .cpu_rst    (cpu_rst),
        .state      (state),
        .step_count (step_count),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         we_total = 0;
    logic [7:0] exp_q[$];
    logic [3:0] mon_addr = 4'd0;
    logic       last_sl = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every mem_we must carry the next accepted word at the next
    // sequential address.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            logic [7:0] w;
            we_total++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL mem_we_unexpected: got write addr %0h expected none", bus.mem_addr);
            end else begin
                w = exp_q.pop_front();
                check("mem_addr", 32'(bus.mem_addr), 32'(mon_addr));
                check("mem_data", 32'({bus.mem_opcode, bus.mem_imm}), 32'(w));
            end
            mon_addr = mon_addr + 4'd1;
        end
    end

    // Applies inputs for one cycle and stops at the falling edge for checks.
    task automatic drive(input logic sl, input logic rn, input logic ht, input logic stp,
                         input logic vld, input logic [3:0] op, input logic [3:0] im,
                         output logic took);
        start_load = sl; run = rn; halt = ht; step = stp;
        bus.load_valid = vld; bus.load_opcode = op; bus.load_imm = im;
        last_sl = sl;
        @(negedge clk);
        took = vld && bus.load_ready;
        if (took) exp_q.push_back({op, im});
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        start_load = 0; run = 0; halt = 0; step = 0;
        bus.load_valid = 0; bus.load_opcode = 0; bus.load_imm = 0;
        if (last_sl) begin
            mon_addr = 4'd0;
            last_sl  = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        logic t;
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0, t);
    endtask

    task automatic load_basic();
        logic t;
        drive(1, 0, 0, 0, 0, 4'h0, 4'h0, t);
        adv();
        for (int c = 1; c <= 16; c++) begin
            drive(0, 0, 0, 0, 1, 4'(c - 1), 4'(16 - c), t);
            check("basic_ready", 32'(bus.load_ready), 32'd1);
            check("basic_we", 32'(bus.mem_we), (c >= 2) ? 32'd1 : 32'd0);
            adv();
        end
        idle_cycle();
        check("basic_end_state", 32'(state), 32'd2);
        check("basic_end_done", 32'(load_done), 32'd1);
        check("basic_end_we", 32'(bus.mem_we), 32'd1);
        check("basic_end_ready", 32'(bus.load_ready), 32'd0);
        check("basic_end_cpu_rst", 32'(cpu_rst), 32'd0);
        adv();
        idle_cycle();
        check("basic_after_we", 32'(bus.mem_we), 32'd0);
        adv();
    endtask

    typedef struct {
        logic       sl, rn, ht, stp, vld;
        logic [3:0] op, im;
        logic [1:0] e_state;
        logic       e_ready, e_we;
        logic [3:0] e_addr;
        logic       e_cpu_rst;
    } vec_t;

    vec_t tv[12];

    initial begin
        logic t;
        int   hs_n;
        int   we_before;
        int   pulses;

        rst = 1'b1;
        start_load = 0; run = 0; halt = 0; step = 0;
        bus.load_valid = 0; bus.load_opcode = 0; bus.load_imm = 0;

        tv[0]  = '{0, 0, 0, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0, 4'h0, 1};
        tv[1]  = '{0, 1, 0, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0, 4'h0, 1};
        tv[2]  = '{0, 0, 1, 1, 0, 4'h0, 4'h0, 2'd0, 0, 0, 4'h0, 1};
        tv[3]  = '{1, 0, 0, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0, 4'h0, 1};
        tv[4]  = '{0, 0, 0, 0, 1, 4'h5, 4'hA, 2'd1, 1, 0, 4'h0, 1};
        tv[5]  = '{0, 0, 0, 0, 1, 4'h6, 4'hB, 2'd1, 1, 1, 4'h0, 1};
        tv[6]  = '{1, 0, 0, 0, 1, 4'h7, 4'h7, 2'd1, 0, 1, 4'h1, 1};
        tv[7]  = '{0, 0, 0, 0, 1, 4'h7, 4'hC, 2'd1, 1, 0, 4'h0, 1};
        tv[8]  = '{0, 0, 0, 0, 0, 4'h0, 4'h0, 2'd1, 1, 1, 4'h0, 1};
        tv[9]  = '{0, 1, 0, 0, 0, 4'h0, 4'h0, 2'd1, 1, 0, 4'h0, 1};
        tv[10] = '{0, 0, 1, 0, 0, 4'h0, 4'h0, 2'd1, 1, 0, 4'h0, 1};
        tv[11] = '{0, 0, 0, 1, 0, 4'h0, 4'h0, 2'd1, 1, 0, 4'h0, 1};

        // Reset values
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(bus.load_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem", 32'({bus.mem_addr, bus.mem_opcode, bus.mem_imm}), 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_count", 32'(step_count), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Command handling in IDLE and early LOAD, with a load restart
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].sl, tv[i].rn, tv[i].ht, tv[i].stp, tv[i].vld, tv[i].op, tv[i].im, t);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tv[i].e_state));
            check($sformatf("vec%0d_ready", i), 32'(bus.load_ready), 32'(tv[i].e_ready));
            check($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(tv[i].e_we));
            if (tv[i].e_we)
                check($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(tv[i].e_addr));
            check($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst), 32'(tv[i].e_cpu_rst));
            check($sformatf("vec%0d_cpu_en", i), 32'(cpu_en), 32'd0);
            adv();
        end

        // Back-to-back load of 16 words
        load_basic();

        // Throttled load: valid only every third cycle
        drive(1, 0, 0, 0, 0, 4'h0, 4'h0, t);
        adv();
        we_before = we_total;
        hs_n = 0;
        for (int cyc = 0; cyc < 100 && hs_n < 16; cyc++) begin
            if (cyc % 3 == 2) drive(0, 0, 0, 0, 1, 4'(hs_n + 3), 4'(hs_n * 5), t);
            else              drive(0, 0, 0, 0, 0, 4'h0, 4'h0, t);
            if (t) hs_n++;
            adv();
        end
        check("thr_handshakes", 32'(hs_n), 32'd16);
        idle_cycle();
        check("thr_state", 32'(state), 32'd2);
        check("thr_ready", 32'(bus.load_ready), 32'd0);
        adv();
        idle_cycle();
        check("thr_we_count", 32'(we_total - we_before), 32'd16);
        check("thr_done", 32'(load_done), 32'd1);
        adv();

        // RUN timing: 20 cycles in RUN, then halt
        drive(0, 1, 0, 0, 0, 4'h0, 4'h0, t);
        check("run0_state", 32'(state), 32'd2);
        check("run0_count", 32'(step_count), 32'd0);
        adv();
        for (int c = 1; c <= 20; c++) begin
            idle_cycle();
            check($sformatf("run%0d_state", c), 32'(state), 32'd3);
            check($sformatf("run%0d_cpu_en", c), 32'(cpu_en), (c % 4 == 0) ? 32'd1 : 32'd0);
            check($sformatf("run%0d_count", c), 32'(step_count), 32'((c - 1) / 4));
            adv();
        end
        drive(0, 0, 1, 0, 0, 4'h0, 4'h0, t);
        check("run21_cpu_en", 32'(cpu_en), 32'd0);
        check("run21_count", 32'(step_count), 32'd5);
        adv();
        for (int c = 0; c < 6; c++) begin
            idle_cycle();
            check("post_halt_state", 32'(state), 32'd2);
            check("post_halt_cpu_en", 32'(cpu_en), 32'd0);
            adv();
        end
        check("post_halt_count", 32'(step_count), 32'd5);

        // Halt in the cycle of a due pulse suppresses it
        drive(0, 1, 0, 0, 0, 4'h0, 4'h0, t);
        adv();
        for (int c = 1; c <= 3; c++) begin
            idle_cycle();
            adv();
        end
        drive(0, 0, 1, 0, 0, 4'h0, 4'h0, t);
        check("supp_cpu_en", 32'(cpu_en), 32'd0);
        adv();
        idle_cycle();
        check("supp_state", 32'(state), 32'd2);
        check("supp_count", 32'(step_count), 32'd5);
        adv();

        // halt + run together in RUN: halt wins
        drive(0, 1, 0, 0, 0, 4'h0, 4'h0, t);
        adv();
        idle_cycle();
        adv();
        drive(0, 1, 1, 0, 0, 4'h0, 4'h0, t);
        check("hr_state_before", 32'(state), 32'd3);
        adv();
        idle_cycle();
        check("hr_state_after", 32'(state), 32'd2);
        check("hr_cpu_en", 32'(cpu_en), 32'd0);
        adv();

        // start_load + halt + run in RUN: load wins and clears the count
        drive(0, 1, 0, 0, 0, 4'h0, 4'h0, t);
        adv();
        for (int c = 1; c <= 4; c++) begin
            idle_cycle();
            if (c == 4) check("slr_pulse", 32'(cpu_en), 32'd1);
            adv();
        end
        drive(1, 1, 1, 0, 0, 4'h0, 4'h0, t);
        check("slr_count_before", 32'(step_count), 32'd6);
        adv();
        idle_cycle();
        check("slr_state", 32'(state), 32'd1);
        check("slr_count", 32'(step_count), 32'd0);
        check("slr_cpu_rst", 32'(cpu_rst), 32'd1);
        check("slr_done", 32'(load_done), 32'd0);
        adv();

        // Reset at the 7th load word
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 1, 4'(k), 4'(15 - k), t);
            adv();
        end
        bus.load_valid = 1; bus.load_opcode = 4'd6; bus.load_imm = 4'd9;
        #1 rst = 1'b1;
        exp_q.delete();
        mon_addr = 4'd0;
        @(negedge clk);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_ready", 32'(bus.load_ready), 32'd0);
        check("mid_rst_mem", 32'({bus.mem_addr, bus.mem_opcode, bus.mem_imm}), 32'd0);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("mid_rst_outs", 32'({cpu_en, load_done, step_count}), 32'd0);
        adv();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 1, 4'hF, 4'hF, t);
            check("post_rst_we", 32'(bus.mem_we), 32'd0);
            check("post_rst_state", 32'(state), 32'd0);
            adv();
        end

        // Single step in HALT
        load_basic();
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            drive(0, 0, 0, 1, 0, 4'h0, 4'h0, t);
            check("step_cmd_cpu_en", 32'(cpu_en), 32'd0);
            adv();
            for (int j = 0; j < 3; j++) begin
                idle_cycle();
                if (cpu_en) pulses++;
                check("step_cpu_en", 32'(cpu_en), (j == 0 && STEP_ON) ? 32'd1 : 32'd0);
                check("step_state", 32'(state), 32'd2);
                adv();
            end
        end
        check("step_pulses", 32'(pulses), STEP_ON ? 32'd3 : 32'd0);
        check("step_count", 32'(step_count), STEP_ON ? 32'd3 : 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, giving the number of clk cycles per CPU step in RUN (legal 2..256).
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have the control inputs start_load, run, halt and step, each 1 bit, each a single-cycle command pulse.
REQ-005 SHALL have load_valid (input, 1), load_opcode (input, 4) and load_imm (input, 4): one program word offered per handshake.
REQ-006 SHALL have load_ready (output, 1): the block accepts a word this cycle.
REQ-007 SHALL have mem_we (output, 1), mem_addr (output, 4), mem_opcode (output, 4) and mem_imm (output, 4): the program-memory write port.
REQ-008 SHALL have cpu_en (output, 1), the CPU clock-enable pulse, and cpu_rst (output, 1), which holds the CPU in reset.
REQ-009 SHALL have state (output, 2), step_count (output, 8) and load_done (output, 1).

Function
REQ-010 SHALL implement the states IDLE=0, LOAD=1, HALT=2 and RUN=3.
REQ-011 SHALL apply command priority when commands coincide: start_load > halt > run > step; lower-priority commands in the same cycle are ignored.
REQ-012 SHALL move from any state to LOAD on start_load, clearing the load address to 0, load_done and step_count.
- A start_load received in LOAD restarts the load at address 0.
REQ-013 SHALL hold load_ready=1 only in LOAD.
- A handshake is load_valid && load_ready.
REQ-014 SHALL register each handshake so that in the next cycle mem_we=1 and mem_addr, mem_opcode, mem_imm carry the accepted word; mem_we is 0 in every other cycle.
REQ-015 SHALL increment the load address by 1 per handshake.
- The handshake at address 15 wraps the address to 0, sets load_done=1 and enters HALT in the next cycle.
REQ-016 SHALL assert cpu_rst=1 in IDLE and LOAD and cpu_rst=0 in HALT and RUN.
REQ-017 SHALL ignore run in IDLE and in LOAD; run in HALT with load_done=1 enters RUN with the divider cleared.
REQ-018 SHALL in RUN increment the divider every cycle and pulse cpu_en=1 for one cycle when the divider equals DIV-1, then clear the divider.
- The first pulse therefore occurs DIV cycles after entering RUN.
REQ-019 SHALL on halt in RUN enter HALT in the next cycle with cpu_en=0 and the divider cleared.
- A cpu_en pulse scheduled in the same cycle as halt is suppressed.
REQ-020 SHALL increment step_count on every cpu_en pulse, wrapping 255 to 0.
REQ-021 SHALL hold cpu_en=0 outside RUN, except for the single-step pulse defined in REQ-025.
REQ-022 SHALL ignore run, halt and step while in IDLE.

Reset
REQ-023 SHALL on rst force state=IDLE and all of the following to 0: load address, divider, step_count, load_done, load_ready, mem_we, mem_addr, mem_opcode, mem_imm, cpu_en.
- cpu_rst is 1 during reset.
REQ-024 SHALL on reset during LOAD or RUN abandon the operation; no further mem_we or cpu_en pulses follow.

Configuration
REQ-025 SHALL honour macro TD4_RUN_CTRL_STEP_EN.
- Defined: step in HALT with load_done=1 produces exactly one cpu_en pulse in the next cycle and remains in HALT.
- Undefined: step is ignored in every state and no step logic is synthesised.

Structure
REQ-026 SHALL take the state encoding enum, the word widths (4-bit opcode, 4-bit immediate, 4-bit address) and the memory depth 16 from shared package td4_pkg.
REQ-027 SHALL place the step divider in one sub-module, td4_step_div, with inputs clk, rst, clear and enable and output pulse.

Verification
REQ-028 SHALL cover the basic load: start_load, then 16 back-to-back words with word k = {k, 15-k}.
- mem_we is seen on 16 consecutive cycles at addresses 0..15 with the matching data.
- load_done=1 and state=HALT follow.
REQ-029 SHALL cover a throttled load: load_valid held high only every third cycle.
- Exactly 16 mem_we pulses occur, the address never skips, and load_ready drops in HALT.
REQ-030 SHALL cover RUN timing with DIV=4: run after a load, run for 20 cycles, then halt.
- cpu_en pulses land on cycles 4, 8, 12, 16 and 20; step_count=5; no pulse follows halt.
REQ-031 SHALL cover simultaneous commands: halt and run in the same cycle while in RUN.
- The block halts; with start_load also asserted it enters LOAD with step_count=0 and cpu_rst=1.
REQ-032 SHALL cover mid-operation reset: rst pulsed at the 7th load word.
- All outputs take their reset values, state=IDLE, and no mem_we appears after rst.
REQ-033 SHALL cover single step with TD4_RUN_CTRL_STEP_EN defined: 3 step pulses in HALT.
- Exactly 3 single-cycle cpu_en pulses, step_count=3, state stays HALT.
- With the macro undefined, cpu_en stays 0.
